// File: rtl/kitchen_pkg.sv
// Shared constants for the kitchen status uplink: frame marker, status bit
// positions and the byte serialiser state encoding.
package kitchen_pkg;

  localparam logic [7:0] SOF         = 8'hA5;
  localparam int         FRAME_BYTES = 3;

  localparam int ST_OPEN    = 0;
  localparam int ST_CLOSED  = 1;
  localparam int ST_GAS     = 2;
  localparam int ST_MODE    = 3;
  localparam int ST_MOVING  = 4;
  localparam int ST_SEQ_LSB = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/kitchen_status_tx_if.sv
// ESP-facing side of the status uplink: serial line and busy flag.
interface kitchen_status_tx_if;

  logic ESP_TX;
  logic TX_BUSY;

  modport master (output ESP_TX, output TX_BUSY);
  modport slave  (input  ESP_TX, input  TX_BUSY);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, each bit held CLKS_PER_BIT cycles.
//
// state    | meaning
// ---------+---------------------------------------------
// TX_IDLE  | line high, waiting for a byte
// TX_START | driving the start bit (low)
// TX_DATA  | shifting out data bits 0..7
// TX_STOP  | driving the stop bit (high)
//
// ready is also raised in the last cycle of the stop bit so the next byte
// is taken on that edge and its start bit follows with no idle gap.
module uart_tx_byte
  import kitchen_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign ready     = (state == TX_IDLE) || ((state == TX_STOP) && baud_last);

  // Bit-level sequencing; tx is registered so the line never glitches.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (valid) begin
            shreg    <= data;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kitchen_status_tx.sv
// Kitchen status uplink: synchronises sensor inputs, detects status changes,
// gas alarms and heartbeat expiry, and sends 3-byte frames {SOF, S, SOF^S}.
module kitchen_status_tx
  import kitchen_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int REPORT_TICKS = 50000000
) (
  input  logic                       CLK_IN,
  input  logic                       RST_N_IN,
  input  logic                       IR3_IN,
  input  logic                       IR4_IN,
  input  logic                       Gas_SS,
  input  logic                       SW_MODE_IN,
  input  logic [3:0]                 BD_IN,
  kitchen_status_tx_if.master        esp
);

  localparam int              HB_W    = (REPORT_TICKS > 1) ? $clog2(REPORT_TICKS) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(REPORT_TICKS - 1);
  // Limit sensors idle high, so their synchronisers reset to 1.
  localparam logic [7:0]      SYNC_RST = 8'b0000_0011;

  logic [7:0]      sync1, sync2;
  logic [4:0]      status_lo, prev_lo;
  logic [2:0]      seq;
  logic [7:0]      snap;
  logic [1:0]      byte_idx;
  logic [HB_W-1:0] hb_cnt;
  logic            pending, active;
  logic            change, gas_rise, hb_hit, trigger;
  logic            frame_go, frame_end;
  logic            byte_valid, byte_ready;
  logic [7:0]      byte_data;
  logic            tx_line;

  // Two-flop synchronisers, packed {BD, mode, gas, IR4, IR3}.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {BD_IN, SW_MODE_IN, Gas_SS, IR4_IN, IR3_IN};
      sync2 <= sync1;
    end
  end

  // Live status bits 4:0 from the synchronised inputs.
  always_comb begin
    status_lo            = '0;
    status_lo[ST_OPEN]   = ~sync2[0];
    status_lo[ST_CLOSED] = ~sync2[1];
    status_lo[ST_GAS]    = sync2[2];
    status_lo[ST_MODE]   = sync2[3];
    status_lo[ST_MOVING] = |sync2[7:4];
  end

  assign change   = (status_lo != prev_lo);
  assign gas_rise = status_lo[ST_GAS] & ~prev_lo[ST_GAS];
  assign hb_hit   = (hb_cnt == HB_LAST);
  assign trigger  = change | gas_rise | hb_hit;

  // A trigger seen while idle starts the frame directly; its effect is
  // already in the snapshot, so pending is not left set behind it.
  assign frame_go  = ~active & byte_ready & (pending | trigger);
  assign frame_end = active & (byte_idx == 2'(FRAME_BYTES - 1)) & byte_ready;

  // Byte offered to the serialiser: SOF on start, then S, then the check byte.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = SOF;
    if (frame_go) begin
      byte_valid = 1'b1;
    end else if (active && (byte_idx < 2'(FRAME_BYTES - 1))) begin
      byte_valid = 1'b1;
      byte_data  = (byte_idx == 2'd0) ? snap : (snap ^ SOF);
    end
  end

  // Frame control: pending flag, heartbeat, snapshot, byte index and seq.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      prev_lo  <= '0;
      pending  <= 1'b1;
      active   <= 1'b0;
      byte_idx <= '0;
      seq      <= '0;
      snap     <= '0;
      hb_cnt   <= '0;
    end else begin
      prev_lo <= status_lo;
      pending <= frame_go ? 1'b0 : (pending | trigger);

      if (frame_go || hb_hit) hb_cnt <= '0;
      else                    hb_cnt <= hb_cnt + HB_W'(1);

      if (frame_go) begin
        active   <= 1'b1;
        byte_idx <= '0;
        snap     <= {seq, status_lo};
      end else if (active) begin
        if (byte_valid && byte_ready) begin
          byte_idx <= byte_idx + 2'd1;
        end else if (frame_end) begin
          active <= 1'b0;
          seq    <= seq + 3'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_sys (CLK_IN),
    .rst_b   (RST_N_IN),
    .valid   (byte_valid),
    .data    (byte_data),
    .ready   (byte_ready),
    .tx      (tx_line)
  );

  assign esp.ESP_TX  = tx_line;
  assign esp.TX_BUSY = active;

endmodule

// File: tb/tb_kitchen_status_tx.sv
// Directed bench for kitchen_status_tx with CLKS_PER_BIT=4, REPORT_TICKS=400.
module tb_kitchen_status_tx;

  localparam int CPB = 4;
  localparam int RT  = 400;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir3   = 1'b1;
  logic       ir4   = 1'b1;
  logic       gas   = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] bd    = 4'b0000;

  kitchen_status_tx_if esp ();

  kitchen_status_tx #(
    .CLKS_PER_BIT(CPB),
    .REPORT_TICKS(RT)
  ) dut (
    .CLK_IN     (clk),
    .RST_N_IN   (rst_n),
    .IR3_IN     (ir3),
    .IR4_IN     (ir4),
    .Gas_SS     (gas),
    .SW_MODE_IN (mode),
    .BD_IN      (bd),
    .esp        (esp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Busy monitor: frame start/end cycle numbers, sampled on the falling edge.
  int   cyc = 0, starts = 0, start_cyc = 0, prev_start_cyc = 0, end_cyc = 0, last_len = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (esp.TX_BUSY === 1'b1 && !busy_q) begin
      starts++;
      prev_start_cyc = start_cyc;
      start_cyc      = cyc;
    end
    if (esp.TX_BUSY !== 1'b1 && busy_q) begin
      end_cyc  = cyc;
      last_len = cyc - start_cyc;
    end
    busy_q = (esp.TX_BUSY === 1'b1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a start bit, then samples each bit mid-cell.
  // Returns after byte2's stop-bit sample, two cycles before the frame ends.
  task automatic rx_frame(input int max_wait, output int lat,
                          output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] b2, output logic ok);
    logic [7:0] by [3];
    lat = 0;
    ok  = 1'b1;
    by[0] = '0; by[1] = '0; by[2] = '0;
    while (esp.ESP_TX !== 1'b0 && lat < max_wait) begin
      wait_cyc(1);
      lat++;
    end
    if (esp.ESP_TX !== 1'b0) begin
      ok = 1'b0;
    end else begin
      wait_cyc(CPB / 2);
      for (int b = 0; b < 3; b++) begin
        if (esp.ESP_TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          wait_cyc(CPB);
          by[b][i] = esp.ESP_TX;
        end
        wait_cyc(CPB);
        if (esp.ESP_TX !== 1'b1) ok = 1'b0;
        if (b < 2) wait_cyc(CPB);
      end
    end
    b0 = by[0];
    b1 = by[1];
    b2 = by[2];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         lat, s0;
    logic [7:0] b0, b1, b2, exp_s;
    logic [2:0] exp_seq;
    logic       ok, all_ok;
    all_ok = 1'b1;

    // Reset state
    wait_cyc(2);
    chk("rst_tx", esp.ESP_TX, 1'b1);
    chk("rst_busy", esp.TX_BUSY, 1'b0);

    // Frame after reset release: A5 00 A5, starts quickly, busy 120 cycles
    rst_n = 1'b1;
    rx_frame(10, lat, b0, b1, b2, ok); all_ok &= ok;
    chk("rst_lat_le4", (lat >= 1 && lat <= 4), 1'b1);
    chk("f0_b0", b0, 8'hA5);
    chk("f0_b1", b1, 8'h00);
    chk("f0_b2", b2, 8'hA5);
    wait_cyc(5);
    chk("f0_busy_len", last_len, 30 * CPB);

    // Idle: nothing goes out
    s0 = starts;
    wait_cyc(20);
    chk("idle_quiet", starts, s0);

    // IR3 low -> A5 21 84 three cycles later; gas and BD change mid-frame
    ir3 = 1'b0;
    fork
      begin
        rx_frame(20, lat, b0, b1, b2, ok);
      end
      begin
        wait_cyc(30);
        gas = 1'b1;
        wait_cyc(30);
        bd = 4'b0001;
      end
    join
    all_ok &= ok;
    chk("ir3_lat", lat, 3);
    chk("f1_b0", b0, 8'hA5);
    chk("f1_b1", b1, 8'h21);
    chk("f1_b2", b2, 8'h84);

    // Single follow-up: seq2 | moving | gas | open = 0x55, check byte 0xF0
    rx_frame(20, lat, b0, b1, b2, ok); all_ok &= ok;
    chk("f2_b0", b0, 8'hA5);
    chk("f2_b1", b1, 8'h55);
    chk("f2_b2", b2, 8'hF0);
    chk("f2_gap", start_cyc - end_cyc, 1);
    s0 = starts;
    wait_cyc(100);
    chk("f2_single", starts, s0);

    // Heartbeat: 400 cycles after previous start, seq3, same low bits: 0x75 / 0xD0
    rx_frame(RT, lat, b0, b1, b2, ok); all_ok &= ok;
    chk("hb_period", start_cyc - prev_start_cyc, RT);
    chk("hb_b0", b0, 8'hA5);
    chk("hb_b1", b1, 8'h75);
    chk("hb_b2", b2, 8'hD0);

    // Eight mode-toggle frames: seq 4..7,0..3
    for (int i = 0; i < 8; i++) begin
      wait_cyc(10);
      mode = ~mode;
      rx_frame(20, lat, b0, b1, b2, ok); all_ok &= ok;
      exp_seq = 3'(4 + i);
      exp_s   = {exp_seq, 1'b1, mode, 1'b1, 1'b0, 1'b1};
      chk($sformatf("wrap%0d_b0", i), b0, 8'hA5);
      chk($sformatf("wrap%0d_b1", i), b1, exp_s);
      chk($sformatf("wrap%0d_b2", i), b2, exp_s ^ 8'hA5);
    end

    // Reset in the middle of byte1
    wait_cyc(10);
    mode = ~mode;
    lat  = 0;
    while (esp.ESP_TX !== 1'b0 && lat < 20) begin
      wait_cyc(1);
      lat++;
    end
    chk("pre_rst_start", esp.ESP_TX, 1'b0);
    wait_cyc(50);
    chk("pre_rst_tx", esp.ESP_TX, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", esp.ESP_TX, 1'b1);
    chk("mid_rst_busy", esp.TX_BUSY, 1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    rx_frame(10, lat, b0, b1, b2, ok); all_ok &= ok;
    chk("post_rst_b0", b0, 8'hA5);
    chk("post_rst_b1", b1, 8'h00);
    chk("post_rst_b2", b2, 8'hA5);

    // Synchronisers catch up after release: seq1 follow-up with live inputs
    rx_frame(20, lat, b0, b1, b2, ok); all_ok &= ok;
    exp_s = {3'd1, 1'b1, mode, 1'b1, 1'b0, 1'b1};
    chk("post_rst_fu_b1", b1, exp_s);
    chk("post_rst_fu_b2", b2, exp_s ^ 8'hA5);

    chk("framing", all_ok, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
